// File: rtl/serial_bit_source.sv
// serial_bit_source: parallel-to-serial stimulus stage for the sequence detector.
// Accepts a WIDTH-bit word on load && ready, then drives it onto w one bit per
// Clock, optionally followed by GAP idle cycles. With GAP == 0 a new word may be
// accepted on the last-bit cycle so consecutive words form one unbroken stream.
//
// Handshake: a word is transferred at a rising Clock edge where load && ready
// are both high; load while ready is low is dropped, never queued, and data_in
// is only sampled on a transferring edge.
module serial_bit_source #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam bit            HAS_GAP  = (GAP > 0);
  localparam logic [3:0]    GAP_LAST = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gcnt_q, gcnt_d;
  logic             w_q, w_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;

  // The bit currently on w is always the "first" end of the shift register.
  function automatic logic first_bit(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  // Advance the shift register by one bit in the configured order.
  always_comb begin
    if (MSB_FIRST) shifted = {sreg_q[WIDTH-2:0], 1'b0};
    else           shifted = {1'b0, sreg_q[WIDTH-1:1]};
  end

  // ready is combinational so a back-to-back load can be taken on the last-bit
  // cycle; it is held low while Resetn is asserted.
  always_comb begin
    ready = Resetn && ((state_q == S_IDLE) ||
                       (state_q == S_SHIFT && cnt_q == '0 && !HAS_GAP));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    w_d     = IDLE_BIT;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d = S_SHIFT;
          sreg_d  = data_in;
          cnt_d   = CNT_LAST;
          w_d     = first_bit(data_in);
          busy_d  = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          sreg_d = shifted;
          cnt_d  = cnt_q - CNT_ONE;
          w_d    = first_bit(shifted);
          busy_d = 1'b1;
          done_d = (cnt_q == CNT_ONE);
        end else if (HAS_GAP) begin
          state_d = S_GAP;
          gcnt_d  = GAP_LAST;
          busy_d  = 1'b1;
        end else if (load) begin
          // Back-to-back: first bit of the new word follows the last bit directly.
          sreg_d = data_in;
          cnt_d  = CNT_LAST;
          w_d    = first_bit(data_in);
          busy_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gcnt_q == 4'd0) begin
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q - 4'd1;
          busy_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partially sent word.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= 4'd0;
      w_q     <= IDLE_BIT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign w         = w_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_bit_source.sv
// tb_serial_bit_source: directed bench for serial_bit_source.
// dut0: WIDTH=8, MSB first, no gap.  dut1: WIDTH=8, LSB first, GAP=2.
module tb_serial_bit_source;

  logic       Clock;
  logic       Resetn;
  logic [7:0] data0, data1;
  logic       load0, load1;
  logic       ready0, w0, busy0, done0;
  logic       ready1, w1, busy1, done1;
  logic [1:0] st0, st1;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];
  logic [2:0] hist;
  logic       z;
  logic       eb;

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .data_in(data0), .load(load0),
    .ready(ready0), .w(w0), .busy(busy0), .done(done0), .state_dbg(st0)
  );

  serial_bit_source #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2), .IDLE_BIT(1'b0)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .data_in(data1), .load(load1),
    .ready(ready1), .w(w1), .busy(busy1), .done(done1), .state_dbg(st1)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // advance one cycle; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d, input bit msb);
    for (int b = 0; b < 8; b++) exp_q.push_back(msb ? d[7-b] : d[b]);
  endtask

  // reference 1101 detector (Mealy, overlapping) on dut0's w
  task automatic det();
    z    = ({hist, w0} == 4'b1101);
    hist = {hist[1:0], w0};
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      eb = 1'bx;
      chk("exp_q_empty", 32'd1, 32'd0);
    end else begin
      eb = exp_q.pop_front();
    end
  endtask

  initial begin
    Resetn = 1'b0;
    load0 = 1'b0; load1 = 1'b0;
    data0 = 8'h00; data1 = 8'h00;
    hist = 3'b000;

    // reset state
    #3;
    chk("rst_w", w0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_ready", ready0, 0);
    chk("rst_ready1", ready1, 0);
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    chk("rel_ready", ready0, 1);

    // plan 6: idle hold for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_w", w0, 0);
      chk("idle_busy", busy0, 0);
      chk("idle_done", done0, 0);
      chk("idle_ready", ready0, 1);
      chk("idle_ready1", ready1, 1);
    end

    // plan 1: single word D0, MSB first
    hist = 3'b000;
    push_word(8'hD0, 1'b1);
    data0 = 8'hD0; load0 = 1'b1;
    chk("p1_ready0", ready0, 1);
    step();
    load0 = 1'b0; data0 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      pop_exp();
      chk("p1_w", w0, eb);
      chk("p1_done", done0, (i == 8));
      chk("p1_ready", ready0, (i == 8));
      chk("p1_busy", busy0, 1);
      det();
      chk("p1_z", z, (i == 4));
      step();
    end
    chk("p1_ready9", ready0, 1);
    chk("p1_busy9", busy0, 0);
    chk("p1_w9", w0, 0);
    chk("p1_done9", done0, 0);

    // plan 2: back-to-back 0D then A0, pattern across the boundary
    hist = 3'b000;
    push_word(8'h0D, 1'b1);
    push_word(8'hA0, 1'b1);
    data0 = 8'h0D; load0 = 1'b1;
    step();
    load0 = 1'b0; data0 = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      pop_exp();
      chk("p2_w", w0, eb);
      chk("p2_done", done0, (i == 8 || i == 16));
      chk("p2_busy", busy0, 1);
      det();
      chk("p2_z", z, (i == 8 || i == 11));
      if (i == 8) begin
        chk("p2_ready8", ready0, 1);
        data0 = 8'hA0; load0 = 1'b1;
      end else begin
        load0 = 1'b0; data0 = 8'h00;
      end
      step();
    end
    chk("p2_busy17", busy0, 0);
    chk("p2_ready17", ready0, 1);

    // plan 3: LSB first with GAP=2; load during gap ignored
    push_word(8'h0B, 1'b0);
    data1 = 8'h0B; load1 = 1'b1;
    step();
    load1 = 1'b0; data1 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      pop_exp();
      chk("p3_w", w1, eb);
      chk("p3_done", done1, (i == 8));
      chk("p3_ready", ready1, 0);
      step();
    end
    for (int i = 9; i <= 10; i++) begin
      chk("p3_gap_w", w1, 0);
      chk("p3_gap_busy", busy1, 1);
      chk("p3_gap_ready", ready1, 0);
      chk("p3_gap_done", done1, 0);
      if (i == 9) begin
        data1 = 8'hFF; load1 = 1'b1;
      end else begin
        load1 = 1'b0; data1 = 8'h00;
      end
      step();
    end
    chk("p3_ready11", ready1, 1);
    chk("p3_busy11", busy1, 0);
    step();
    chk("p3_busy12", busy1, 0);
    chk("p3_w12", w1, 0);

    // plan 4: load FF while busy is dropped
    push_word(8'h5A, 1'b1);
    data0 = 8'h5A; load0 = 1'b1;
    step();
    load0 = 1'b0; data0 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      pop_exp();
      chk("p4_w", w0, eb);
      if (i == 3) begin
        data0 = 8'hFF; load0 = 1'b1;
      end else begin
        load0 = 1'b0; data0 = 8'h00;
      end
      step();
    end
    for (int i = 9; i <= 11; i++) begin
      chk("p4_after_busy", busy0, 0);
      chk("p4_after_w", w0, 0);
      step();
    end

    // plan 5: asynchronous reset mid-word
    data0 = 8'hD0; load0 = 1'b1;
    step();
    load0 = 1'b0; data0 = 8'h00;
    step(); step(); step();
    chk("p5_w4", w0, 1);
    chk("p5_busy4", busy0, 1);
    #3;
    Resetn = 1'b0;
    #1;
    chk("p5_rst_w", w0, 0);
    chk("p5_rst_busy", busy0, 0);
    chk("p5_rst_done", done0, 0);
    chk("p5_rst_ready", ready0, 0);
    step(); step();
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    chk("p5_rel_ready", ready0, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("p5_no_done", done0, 0);
      chk("p5_no_busy", busy0, 0);
    end
    exp_q.delete();
    push_word(8'hA5, 1'b1);
    data0 = 8'hA5; load0 = 1'b1;
    step();
    load0 = 1'b0; data0 = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      pop_exp();
      chk("p5_w", w0, eb);
      chk("p5_done", done0, (i == 8));
      step();
    end
    chk("p5_end_busy", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
